dram_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous data RAM between `NCORES` core memory ports. Each core presents a read or write request with address and data. The arbiter serialises the requests onto the RAM address/data/write-enable lines, returns read data on a per-core lane, and pulses a per-core `acq` when the access completes. It sits between the cores' `Mem_Ctrl`/`DAddress`/`Ddout` outputs and the DRAM instance. Its `busy` output feeds the cycle-count logic.

---
 rtl/dram_rr_arbiter_if.sv | 46 ++++
 rtl/dram_rr_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dram_rr_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dram_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_rr_arbiter_if
// Bundles the core request/response bus and the RAM port of the DRAM
// round-robin arbiter.
//
// Signals
//   rden, wren   per-core read / write requests (bit i = core i)
//   Address      per-core address, core i at [i*AW +: AW]
//   Din          per-core write data, core i at [i*DW +: DW]
//   acq          one-hot completion pulse back to the cores
//   Dq           per-core registered read-data lanes
//   RAMAddress   address to the single-port RAM
//   RAMDin       write data to the RAM
//   RAMwren      RAM write enable
//   RAMq         read data coming back from the RAM
//
// Modports
//   slave   arbiter side (consumes requests and RAMq, drives everything else)
//   master  environment side (cores plus the RAM instance)
// -----------------------------------------------------------------------------
interface dram_rr_arbiter_if #(
   parameter int NCORES = 2,
   parameter int AW     = 8,
   parameter int DW     = 8
);
   logic [NCORES-1:0]    rden;
   logic [NCORES-1:0]    wren;
   logic [NCORES*AW-1:0] Address;
   logic [NCORES*DW-1:0] Din;
   logic [NCORES-1:0]    acq;
   logic [NCORES*DW-1:0] Dq;
   logic [AW-1:0]        RAMAddress;
   logic [DW-1:0]        RAMDin;
   logic                 RAMwren;
   logic [DW-1:0]        RAMq;

   modport slave (
      input  rden, wren, Address, Din, RAMq,
      output acq, Dq, RAMAddress, RAMDin, RAMwren
   );

   modport master (
      output rden, wren, Address, Din, RAMq,
      input  acq, Dq, RAMAddress, RAMDin, RAMwren
   );
endinterface

// File: rtl/dram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dram_rr_arbiter
// Shares one single-port synchronous data RAM between NCORES core memory
// ports. Requests are served one at a time in round-robin order; each access
// walks IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> ACK -> IDLE.
//
// Ports
//   CLK   system clock, all state changes on the rising edge
//   rst   asynchronous, active-high reset
//   bus   dram_rr_arbiter_if.slave: core requests, acq/Dq responses, RAM port
//   busy  high whenever the FSM is not in IDLE
//
// Parameters
//   NCORES  number of requesting cores (>= 2)
//   AW, DW  address / data width
//   RD_LAT  cycles from address at the RAM to valid RAMq (>= 1)
// -----------------------------------------------------------------------------
module dram_rr_arbiter #(
   parameter int NCORES = 2,
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              rst,
   dram_rr_arbiter_if.slave  bus,
   output logic              busy
);

   localparam int IW = $clog2(NCORES);
   localparam int CW = $clog2(RD_LAT + 1);

   localparam logic [IW-1:0] LAST_RST = IW'(NCORES - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   state_t               state;
   logic [IW-1:0]        last;       // most recently granted core
   logic [IW-1:0]        own;        // core owning the current access
   logic                 own_wr;     // current access is a write
   logic                 mask_own;   // first IDLE after ACK: ignore req[own]
   logic [CW-1:0]        cnt;        // read latency countdown
   logic [NCORES-1:0]    acq_q;
   logic [NCORES*DW-1:0] dq;
   logic [AW-1:0]        ram_addr;
   logic [DW-1:0]        ram_din;
   logic                 ram_wren;
   logic                 busy_q;

   logic [NCORES-1:0]    req;
   logic [NCORES-1:0]    elig;
   logic [IW-1:0]        win;
   logic                 win_valid;
   logic                 hit;
   int                   pos;
   logic [AW-1:0]        sel_addr;
   logic [DW-1:0]        sel_din;
   logic                 sel_wr;

   // One-hot vector with only bit idx set.
   function automatic logic [NCORES-1:0] onehot(input logic [IW-1:0] idx);
      onehot = {{(NCORES-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Eligible requesters: the core just served is hidden for one IDLE cycle
   // because it is allowed to keep its request up for the cycle after acq.
   always_comb begin
      req  = bus.rden | bus.wren;
      elig = mask_own ? (req & ~onehot(own)) : req;
   end

   // Round-robin search starting just after the last granted core.
   always_comb begin
      win       = '0;
      win_valid = 1'b0;
      hit       = 1'b0;
      pos       = 0;
      for (int k = 1; k <= NCORES; k++) begin
         pos       = (int'(last) + k >= NCORES) ? (int'(last) + k - NCORES) : (int'(last) + k);
         hit       = elig[IW'(pos)] & ~win_valid;
         win       = hit ? IW'(pos) : win;
         win_valid = win_valid | hit;
      end
   end

   // Pick address, data and direction of the winning core; write wins over read.
   always_comb begin
      sel_addr = '0;
      sel_din  = '0;
      sel_wr   = 1'b0;
      for (int k = 0; k < NCORES; k++) begin
         sel_addr = (win == IW'(k)) ? bus.Address[k*AW +: AW] : sel_addr;
         sel_din  = (win == IW'(k)) ? bus.Din[k*DW +: DW]     : sel_din;
         sel_wr   = (win == IW'(k)) ? bus.wren[k]             : sel_wr;
      end
   end

   // Access FSM with all outputs registered.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         last     <= LAST_RST;
         own      <= '0;
         own_wr   <= 1'b0;
         mask_own <= 1'b0;
         cnt      <= '0;
         acq_q    <= '0;
         dq       <= '0;
         ram_addr <= '0;
         ram_din  <= '0;
         ram_wren <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               mask_own <= 1'b0;
               acq_q    <= '0;
               if (win_valid) begin
                  own      <= win;
                  last     <= win;
                  own_wr   <= sel_wr;
                  ram_addr <= sel_addr;
                  ram_din  <= sel_din;
                  ram_wren <= sel_wr;
                  busy_q   <= 1'b1;
                  state    <= S_ISSUE;
               end else begin
                  busy_q   <= 1'b0;
                  state    <= S_IDLE;
               end
            end

            S_ISSUE: begin
               // RAM sees the access during this cycle; write enable is a single pulse.
               ram_wren <= 1'b0;
               if (own_wr) begin
                  acq_q <= onehot(own);
                  state <= S_ACK;
               end else begin
                  cnt   <= CNT_LOAD;
                  state <= S_WAIT;
               end
            end

            S_WAIT: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  // Last wait cycle: RAMq is valid now, so the lane is ready in ACK.
                  for (int k = 0; k < NCORES; k++) begin
                     if (own == IW'(k)) begin
                        dq[k*DW +: DW] <= bus.RAMq;
                     end else begin
                        dq[k*DW +: DW] <= dq[k*DW +: DW];
                     end
                  end
                  acq_q <= onehot(own);
                  state <= S_ACK;
               end else begin
                  state <= S_WAIT;
               end
            end

            S_ACK: begin
               acq_q    <= '0;
               busy_q   <= 1'b0;
               mask_own <= 1'b1;
               state    <= S_IDLE;
            end

            default: begin
               acq_q    <= '0;
               ram_wren <= 1'b0;
               busy_q   <= 1'b0;
               mask_own <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.acq        = acq_q;
   assign bus.Dq         = dq;
   assign bus.RAMAddress = ram_addr;
   assign bus.RAMDin     = ram_din;
   assign bus.RAMwren    = ram_wren;
   assign busy           = busy_q;

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_rr_arbiter
// Directed bench for dram_rr_arbiter (NCORES=2, AW=8, DW=8, RD_LAT=1) with a
// behavioural synchronous RAM (one cycle read latency, read-before-write).
// obs packs the arbiter outputs as {busy, acq[1:0], RAMwren, RAMAddress, RAMDin}
// so the first hex digit is {busy,acq,wren}, then two digits address, two data.
// -----------------------------------------------------------------------------
module tb_dram_rr_arbiter;
   localparam int NC = 2;
   localparam int AW = 8;
   localparam int DW = 8;

   logic CLK = 1'b0;
   logic rst;
   logic busy;
   int   n_cmp = 0;
   int   n_bad = 0;

   dram_rr_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

   dram_rr_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
      .CLK  (CLK),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 CLK = ~CLK;

   logic [7:0] mem [0:255];
   logic [19:0] obs;
   assign obs = {busy, bus.acq, bus.RAMwren, bus.RAMAddress, bus.RAMDin};

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
   end

   always @(posedge CLK) begin
      if (bus.RAMwren) mem[bus.RAMAddress] <= bus.RAMDin;
      bus.RAMq <= mem[bus.RAMAddress];
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.rden    = 2'($urandom);
         bus.wren    = 2'($urandom);
         bus.Address = 16'($urandom);
         bus.Din     = 16'($urandom);
         tick();
      end
      n_cmp++; if (obs !== 20'h00000) begin n_bad++; $display("FAIL rst_outputs: got %h want %h", obs, 20'h00000); end
      n_cmp++; if (bus.Dq !== 16'h0000) begin n_bad++; $display("FAIL rst_dq: got %h want %h", bus.Dq, 16'h0000); end
      bus.rden = 2'b00; bus.wren = 2'b00; bus.Address = 16'h0000; bus.Din = 16'h0000;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (obs !== 20'h00000) begin n_bad++; $display("FAIL rst_idle_%0d: got %h want %h", i, obs, 20'h00000); end
      end
   endtask

   task automatic test_single_write();
      bus.wren = 2'b01; bus.Address = 16'h0010; bus.Din = 16'h00A5;
      tick();
      n_cmp++; if (obs !== 20'h910A5) begin n_bad++; $display("FAIL wr_issue: got %h want %h", obs, 20'h910A5); end
      tick();
      n_cmp++; if (obs !== 20'hA10A5) begin n_bad++; $display("FAIL wr_ack: got %h want %h", obs, 20'hA10A5); end
      tick();
      n_cmp++; if (obs !== 20'h010A5) begin n_bad++; $display("FAIL wr_idle1: got %h want %h", obs, 20'h010A5); end
      bus.wren = 2'b00;
      tick();
      n_cmp++; if (obs !== 20'h010A5) begin n_bad++; $display("FAIL wr_idle2: got %h want %h", obs, 20'h010A5); end
   endtask

   task automatic test_read_back();
      bus.rden = 2'b10; bus.Address = 16'h1000; bus.Din = 16'h0000;
      tick();
      n_cmp++; if (obs !== 20'h81000) begin n_bad++; $display("FAIL rd_issue: got %h want %h", obs, 20'h81000); end
      tick();
      n_cmp++; if (obs !== 20'h81000) begin n_bad++; $display("FAIL rd_wait: got %h want %h", obs, 20'h81000); end
      n_cmp++; if (bus.Dq !== 16'h0000) begin n_bad++; $display("FAIL rd_wait_dq: got %h want %h", bus.Dq, 16'h0000); end
      tick();
      n_cmp++; if (obs !== 20'hC1000) begin n_bad++; $display("FAIL rd_ack: got %h want %h", obs, 20'hC1000); end
      n_cmp++; if (bus.Dq !== 16'hA500) begin n_bad++; $display("FAIL rd_ack_dq: got %h want %h", bus.Dq, 16'hA500); end
      bus.rden = 2'b00;
      tick();
      n_cmp++; if (obs !== 20'h01000) begin n_bad++; $display("FAIL rd_idle: got %h want %h", obs, 20'h01000); end
      n_cmp++; if (bus.Dq !== 16'hA500) begin n_bad++; $display("FAIL rd_idle_dq: got %h want %h", bus.Dq, 16'hA500); end
   endtask

   // rden and wren both set on core0: must behave as a write.
   task automatic test_held_request();
      logic [19:0] exp_h [8];
      exp_h = '{20'h9203C, 20'hA203C, 20'h0203C, 20'h0203C,
                20'h9203C, 20'hA203C, 20'h0203C, 20'h0203C};
      bus.rden = 2'b01; bus.wren = 2'b01; bus.Address = 16'h0020; bus.Din = 16'h003C;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++; if (obs !== exp_h[i]) begin n_bad++; $display("FAIL held_c%0d: got %h want %h", i, obs, exp_h[i]); end
         if (i == 5) begin bus.rden = 2'b00; bus.wren = 2'b00; end
      end
      n_cmp++; if (bus.Dq !== 16'hA500) begin n_bad++; $display("FAIL held_dq: got %h want %h", bus.Dq, 16'hA500); end
   endtask

   task automatic test_read_lane0();
      bus.rden = 2'b01; bus.Address = 16'h0020; bus.Din = 16'h0000;
      tick();
      n_cmp++; if (obs !== 20'h82000) begin n_bad++; $display("FAIL rd0_issue: got %h want %h", obs, 20'h82000); end
      tick();
      tick();
      n_cmp++; if (obs !== 20'hA2000) begin n_bad++; $display("FAIL rd0_ack: got %h want %h", obs, 20'hA2000); end
      n_cmp++; if (bus.Dq !== 16'hA53C) begin n_bad++; $display("FAIL rd0_dq: got %h want %h", bus.Dq, 16'hA53C); end
      bus.rden = 2'b00;
      tick();
      tick();
      n_cmp++; if (bus.Dq !== 16'hA53C) begin n_bad++; $display("FAIL rd0_dq_hold: got %h want %h", bus.Dq, 16'hA53C); end
   endtask

   task automatic test_reset_during_wait();
      bus.rden = 2'b01; bus.Address = 16'h0010; bus.Din = 16'h0000;
      tick();
      tick();
      n_cmp++; if (obs !== 20'h81000) begin n_bad++; $display("FAIL rw_wait: got %h want %h", obs, 20'h81000); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (obs !== 20'h00000) begin n_bad++; $display("FAIL rw_async: got %h want %h", obs, 20'h00000); end
      n_cmp++; if (bus.Dq !== 16'h0000) begin n_bad++; $display("FAIL rw_async_dq: got %h want %h", bus.Dq, 16'h0000); end
      bus.rden = 2'b00;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (obs !== 20'h00000) begin n_bad++; $display("FAIL rw_noacq_%0d: got %h want %h", i, obs, 20'h00000); end
      end
      bus.wren = 2'b10; bus.Address = 16'h3000; bus.Din = 16'h5A00;
      tick();
      n_cmp++; if (obs !== 20'h9305A) begin n_bad++; $display("FAIL rw_wr_issue: got %h want %h", obs, 20'h9305A); end
      tick();
      n_cmp++; if (obs !== 20'hC305A) begin n_bad++; $display("FAIL rw_wr_ack: got %h want %h", obs, 20'hC305A); end
      bus.wren = 2'b00;
      tick();
      n_cmp++; if (obs !== 20'h0305A) begin n_bad++; $display("FAIL rw_wr_idle: got %h want %h", obs, 20'h0305A); end
      tick();
   endtask

   // Both cores hold write requests; grants must alternate 0,1,0,1 every 3 cycles.
   // Entries are {acq[1:0], RAMwren, RAMAddress}.
   task automatic test_contention();
      logic [10:0] exp_c [12];
      logic [10:0] got;
      exp_c = '{{3'b001, 8'h40}, {3'b010, 8'h40}, {3'b000, 8'h40},
                {3'b001, 8'h41}, {3'b100, 8'h41}, {3'b000, 8'h41},
                {3'b001, 8'h40}, {3'b010, 8'h40}, {3'b000, 8'h40},
                {3'b001, 8'h41}, {3'b100, 8'h41}, {3'b000, 8'h41}};
      bus.wren = 2'b11; bus.rden = 2'b10; bus.Address = 16'h4140; bus.Din = 16'h2211;
      for (int i = 0; i < 12; i++) begin
         tick();
         got = {bus.acq, bus.RAMwren, bus.RAMAddress};
         n_cmp++; if (got !== exp_c[i]) begin n_bad++; $display("FAIL cont_c%0d: got %h want %h", i, got, exp_c[i]); end
         if (i == 10) begin bus.wren = 2'b00; bus.rden = 2'b00; end
      end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_end_busy: got %b want %b", busy, 1'b0); end
      n_cmp++; if ({mem[8'h40], mem[8'h41]} !== 16'h1122) begin n_bad++; $display("FAIL cont_mem: got %h want %h", {mem[8'h40], mem[8'h41]}, 16'h1122); end
   endtask

   initial begin
      rst = 1'b1;
      bus.rden = 2'b00; bus.wren = 2'b00; bus.Address = 16'h0000; bus.Din = 16'h0000;
      test_reset();
      test_single_write();
      test_read_back();
      test_held_request();
      test_read_lane0();
      test_reset_during_wait();
      test_contention();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
